spi_note_transmitter: RTL and testbench
=======================================

SPI_NOTE_TRANSMITTER -- requirements
Module: spi_note_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in i_clk cycles; legal range 1 to 255.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: SCLK-low idle cycles between bytes; legal range 0 to 255, 0 = no gap.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_note_status, input, 1: 1 = note on, 0 = note off.
REQ-006 SHALL have port i_voice_index, input, 8: target voice.
REQ-007 SHALL have port i_tuning_code, input, 32: phase-increment word.
REQ-008 SHALL have port i_velocity, input, 7: note velocity.
REQ-009 SHALL have port i_valid, input, 1: packet fields valid.
REQ-010 SHALL have port o_ready, output, 1: transmitter can accept a packet.
REQ-011 SHALL have port o_SPI_sclk, output, 1: SPI clock, mode 0, idle low.
REQ-012 SHALL have port o_SPI_mosi, output, 1: serial data, MSB first.
REQ-013 SHALL have port o_SPI_cs_n, output, 1: active-low frame select.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse at packet completion.

Function
REQ-015 SHALL treat a cycle with i_valid=1 and o_ready=1 as packet acceptance, latching all input fields into a 48-bit shift register.
REQ-016 SHALL order the frame as byte0={i_note_status,i_velocity[6:0]}, byte1=i_voice_index, bytes2-5=i_tuning_code[31:24],[23:16],[15:8],[7:0].
REQ-017 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, GAP, DONE.
REQ-018 SHALL, on the cycle after acceptance, enter SHIFT_LO with o_ready=0, o_SPI_cs_n=0, o_SPI_mosi=frame bit 47.
REQ-019 SHALL hold o_SPI_sclk=0 for CLK_DIV cycles in SHIFT_LO, then o_SPI_sclk=1 for CLK_DIV cycles in SHIFT_HI; each bit period is 2*CLK_DIV cycles.
REQ-020 SHALL update o_SPI_mosi only on SHIFT_HI->SHIFT_LO or GAP->SHIFT_LO transitions (SCLK falling), so data is stable at every rising SCLK edge.
REQ-021 SHALL, after bits 8, 16, 24, 32 and 40 complete, enter GAP for GAP_CYCLES cycles with o_SPI_sclk=0, o_SPI_cs_n=0 and o_SPI_mosi held; GAP_CYCLES=0 skips GAP.
REQ-022 SHALL not enter GAP after the last bit (48); it goes to DONE.
REQ-023 SHALL, in DONE (exactly one cycle), drive o_done=1, o_SPI_cs_n=1, o_SPI_sclk=0, o_SPI_mosi=0, o_ready=0, then return to IDLE.
REQ-024 SHALL drive o_ready=1 only in IDLE; minimum cs_n-high time between frames is therefore 2 cycles (DONE + accepting IDLE cycle).
REQ-025 SHALL ignore i_valid and all field inputs outside IDLE; field changes mid-frame do not alter transmitted bits.
REQ-026 SHALL take 96*CLK_DIV + 5*GAP_CYCLES + 1 cycles from acceptance cycle to the o_done cycle (defaults: 425).
REQ-027 SHALL use a bit counter of 6 bits (0-47) and a divide counter wide enough for max(CLK_DIV,GAP_CYCLES); no counter may wrap within a frame.

Reset
REQ-028 SHALL, when i_reset=1 at a clock edge, enter IDLE with o_ready=1, o_SPI_sclk=0, o_SPI_mosi=0, o_SPI_cs_n=1, o_done=0, counters and shift register cleared.
REQ-029 SHALL give reset priority over acceptance and over any in-progress frame; an aborted frame produces no o_done pulse.

Verification
REQ-030 SHALL be verified: reset held 3 cycles -> o_ready=1, sclk=0, mosi=0, cs_n=1, done=0.
REQ-031 SHALL be verified: defaults, accept status=1, velocity=0x64, voice=0x03, tuning=0x12345678 -> bytes E4,03,12,34,56,78 on rising SCLK, 48 rising edges, o_done 425 cycles after acceptance.
REQ-032 SHALL be verified: i_valid held high for two packets -> second accepted on first IDLE cycle after DONE, cs_n high exactly 2 cycles between frames.
REQ-033 SHALL be verified: fields changed and i_valid pulsed mid-frame -> transmitted frame unchanged, no extra frame.
REQ-034 SHALL be verified: reset asserted during byte 3 -> idle outputs next cycle, no o_done; subsequent packet transmits correctly.
REQ-035 SHALL be verified: CLK_DIV=1, GAP_CYCLES=0 -> contiguous 48-bit burst, o_done 97 cycles after acceptance.

Source files
------------

// File: rtl/spi_note_transmitter.sv
// Serialises a 48-bit note packet (status/velocity, voice, tuning word) over
// mode-0 SPI, MSB first, with optional SCLK-low gaps between bytes.
module spi_note_transmitter #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_note_status,
    input  logic [7:0]  i_voice_index,
    input  logic [31:0] i_tuning_code,
    input  logic [6:0]  i_velocity,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_SPI_sclk,
    output logic        o_SPI_mosi,
    output logic        o_SPI_cs_n,
    output logic        o_done
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam bit         GAP_EN   = (GAP_CYCLES != 0);

    state_t      state_q;
    logic [47:0] shreg_q;
    logic [5:0]  bit_cnt_q;
    logic [7:0]  div_cnt_q;
    logic        ready_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        cs_n_q;
    logic        done_q;
    logic [47:0] frame_d;

    assign frame_d = {i_note_status, i_velocity, i_voice_index, i_tuning_code};

    // Frame sequencer: state, counters, shift register and every registered output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            shreg_q   <= 48'd0;
            bit_cnt_q <= 6'd0;
            div_cnt_q <= 8'd0;
            ready_q   <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        state_q   <= SHIFT_LO;
                        shreg_q   <= frame_d;
                        mosi_q    <= frame_d[47];
                        bit_cnt_q <= 6'd0;
                        div_cnt_q <= 8'd0;
                        ready_q   <= 1'b0;
                        cs_n_q    <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt_q == DIV_LAST) begin
                        state_q   <= SHIFT_HI;
                        sclk_q    <= 1'b1;
                        div_cnt_q <= 8'd0;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= 8'd0;
                        sclk_q    <= 1'b0;
                        if (bit_cnt_q == 6'd47) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            shreg_q   <= {shreg_q[46:0], 1'b0};
                            // MOSI keeps the last bit of the byte while the gap runs
                            if (GAP_EN && (bit_cnt_q[2:0] == 3'd7)) begin
                                state_q <= GAP;
                            end else begin
                                state_q <= SHIFT_LO;
                                mosi_q  <= shreg_q[46];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (div_cnt_q == GAP_LAST) begin
                        state_q   <= SHIFT_LO;
                        mosi_q    <= shreg_q[47];
                        div_cnt_q <= 8'd0;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    sclk_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_SPI_sclk = sclk_q;
    assign o_SPI_mosi = mosi_q;
    assign o_SPI_cs_n = cs_n_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_spi_note_transmitter.sv
// Bench for spi_note_transmitter: two instances (default timing and CLK_DIV=1/GAP=0)
// are observed by an SCLK-edge monitor and compared against a byte-level packet model.
module tb_spi_note_transmitter;
    typedef struct {
        logic        s;
        logic [6:0]  v;
        logic [7:0]  vo;
        logic [31:0] t;
        logic [47:0] f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [6:0]  vel;
    logic [7:0]  voice;
    logic [31:0] tun;
    logic [1:0]  valid;
    logic [1:0]  ready_w, sclk_w, mosi_w, cs_w, done_w;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          lat_exp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_note_transmitter #(.CLK_DIV(4), .GAP_CYCLES(8)) u_a (
        .i_clk(clk), .i_reset(rst), .i_note_status(st), .i_voice_index(voice),
        .i_tuning_code(tun), .i_velocity(vel), .i_valid(valid[0]), .o_ready(ready_w[0]),
        .o_SPI_sclk(sclk_w[0]), .o_SPI_mosi(mosi_w[0]), .o_SPI_cs_n(cs_w[0]), .o_done(done_w[0])
    );

    spi_note_transmitter #(.CLK_DIV(1), .GAP_CYCLES(0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_note_status(st), .i_voice_index(voice),
        .i_tuning_code(tun), .i_velocity(vel), .i_valid(valid[1]), .o_ready(ready_w[1]),
        .o_SPI_sclk(sclk_w[1]), .o_SPI_mosi(mosi_w[1]), .o_SPI_cs_n(cs_w[1]), .o_done(done_w[1])
    );

    // Line monitor: bits captured on rising SCLK while selected, done pulses, cs_n-high runs
    logic [47:0] cap [2];
    int          edges [2]    = '{0, 0};
    int          dones [2]    = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    int          unstable [2] = '{0, 0};
    int          cs_run [2]   = '{0, 0};
    int          cs_gap [2]   = '{0, 0};
    logic [1:0]  sclk_p = 2'b00;
    logic [1:0]  mosi_p = 2'b00;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!cs_w[d] && sclk_w[d] && !sclk_p[d]) begin
                cap[d]   = {cap[d][46:0], mosi_w[d]};
                edges[d] = edges[d] + 1;
                if (mosi_w[d] !== mosi_p[d]) unstable[d] = unstable[d] + 1;
            end
            if (done_w[d]) begin
                dones[d]    = dones[d] + 1;
                done_cyc[d] = cyc;
            end
            if (cs_w[d]) begin
                cs_run[d] = cs_run[d] + 1;
            end else if (cs_run[d] != 0) begin
                cs_gap[d] = cs_run[d];
                cs_run[d] = 0;
            end
        end
        sclk_p = sclk_w;
        mosi_p = mosi_w;
    end

    function automatic logic [47:0] model_frame(logic s, logic [6:0] v, logic [7:0] vo, logic [31:0] t);
        logic [7:0]  b [6];
        logic [47:0] f;
        f    = 48'd0;
        b[0] = {s, v};
        b[1] = vo;
        for (int k = 0; k < 4; k++) b[2 + k] = t[31 - 8 * k -: 8];
        for (int k = 0; k < 6; k++) f = {f[39:0], b[k]};
        return f;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        r.s  = 1'($urandom_range(0, 1));
        r.v  = 7'($urandom_range(0, 127));
        r.vo = 8'($urandom_range(0, 255));
        r.t  = 32'($urandom);
        r.f  = model_frame(r.s, r.v, r.vo, r.t);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input vec_t p);
        st = p.s; vel = p.v; voice = p.vo; tun = p.t;
        valid[d] = 1'b1;
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        @(negedge clk);
        while (!ready_w[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(ready_w[d]), 64'd1);
    endtask

    task automatic wait_done(input int d, input string nm);
        int   n = 0;
        logic ok = 1'b0;
        while (n < 2000 && !ok) begin
            @(negedge clk);
            if (done_w[d]) ok = 1'b1;
            n++;
        end
        #1;
        chk({nm, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic run_frame(input int d, input string nm, input vec_t p);
        int acc, e0, dn0, u0;
        @(negedge clk); #1;
        e0 = edges[d]; dn0 = dones[d]; u0 = unstable[d];
        wait_ready(d);
        drive(d, p);
        acc = cyc;
        @(negedge clk);
        valid[d] = 1'b0;
        chk({nm, "_cs_low"}, 64'(cs_w[d]), 64'd0);
        wait_done(d, nm);
        chk({nm, "_frame"}, 64'(cap[d]), 64'(p.f));
        chk({nm, "_edges"}, 64'(edges[d] - e0), 64'd48);
        chk({nm, "_latency"}, 64'(done_cyc[d] - acc), 64'(lat_exp[d]));
        chk({nm, "_stable"}, 64'(unstable[d] - u0), 64'd0);
        chk({nm, "_done_out"}, 64'({ready_w[d], sclk_w[d], mosi_w[d], cs_w[d]}), 64'b0001);
        @(negedge clk);
        chk({nm, "_pulse_idle"}, 64'({done_w[d], ready_w[d]}), 64'b01);
        chk({nm, "_done_cnt"}, 64'(dones[d] - dn0), 64'd1);
    endtask

    vec_t tbl [4];
    vec_t p1, p2;
    int   acc1, acc2, e0, dn0, n;

    initial begin
        lat_exp[0] = 96 * 4 + 5 * 8 + 1;
        lat_exp[1] = 96 * 1 + 5 * 0 + 1;
        tbl[0] = '{1'b1, 7'h64, 8'h03, 32'h1234_5678, 48'hE4_03_12_34_56_78};
        tbl[1] = '{1'b0, 7'h7F, 8'hFF, 32'h0000_0000, 48'h7F_FF_00_00_00_00};
        tbl[2] = '{1'b1, 7'h00, 8'hA5, 32'hFFFF_FFFF, 48'h80_A5_FF_FF_FF_FF};
        tbl[3] = '{1'b0, 7'h2A, 8'h5A, 32'h8000_0001, 48'h2A_5A_80_00_00_01};

        rst = 1'b1; valid = 2'b00; st = 1'b0; vel = 7'd0; voice = 8'd0; tun = 32'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("reset_out", 64'({ready_w[d], sclk_w[d], mosi_w[d], cs_w[d], done_w[d]}), 64'b10010);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(0, "tbl_a", tbl[i]);
            run_frame(1, "tbl_b", tbl[i]);
        end
        for (int i = 0; i < 4; i++) run_frame(0, "rand_a", rand_vec());
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(1, "rand_b", rand_vec());
        end

        // Back-to-back: valid held high, second packet taken on the IDLE after DONE
        p1 = rand_vec(); p2 = rand_vec();
        @(negedge clk); #1;
        dn0 = dones[0];
        wait_ready(0);
        drive(0, p1);
        @(negedge clk);
        drive(0, p2);
        wait_done(0, "b2b_first");
        chk("b2b_first_frame", 64'(cap[0]), 64'(p1.f));
        @(negedge clk);
        chk("b2b_ready_idle", 64'(ready_w[0]), 64'd1);
        acc2 = cyc;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("b2b_second_cs", 64'(cs_w[0]), 64'd0);
        wait_done(0, "b2b_second");
        chk("b2b_second_frame", 64'(cap[0]), 64'(p2.f));
        chk("b2b_second_lat", 64'(done_cyc[0] - acc2), 64'(lat_exp[0]));
        chk("b2b_cs_high", 64'(cs_gap[0]), 64'd2);
        chk("b2b_done_cnt", 64'(dones[0] - dn0), 64'd2);

        // Mid-frame field changes and valid pulses must be ignored
        p1 = rand_vec();
        repeat (3) @(negedge clk); #1;
        dn0 = dones[0];
        wait_ready(0);
        drive(0, p1);
        acc1 = cyc;
        @(negedge clk);
        valid[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            repeat (40) @(negedge clk);
            drive(0, rand_vec());
            @(negedge clk);
            valid[0] = 1'b0;
        end
        wait_done(0, "midchg");
        chk("midchg_frame", 64'(cap[0]), 64'(p1.f));
        chk("midchg_lat", 64'(done_cyc[0] - acc1), 64'(lat_exp[0]));
        repeat (40) @(negedge clk); #1;
        chk("midchg_no_extra", 64'(dones[0] - dn0), 64'd1);
        chk("midchg_idle", 64'({ready_w[0], cs_w[0]}), 64'b11);

        // Reset during byte 3 aborts the frame without a done pulse
        p1 = rand_vec();
        @(negedge clk); #1;
        e0 = edges[0]; dn0 = dones[0];
        wait_ready(0);
        drive(0, p1);
        @(negedge clk);
        valid[0] = 1'b0;
        n = 0;
        while ((edges[0] - e0) < 20 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abort_in_byte3", 64'((edges[0] - e0) == 20), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle_out", 64'({ready_w[0], sclk_w[0], mosi_w[0], cs_w[0], done_w[0]}), 64'b10010);
        repeat (450) @(negedge clk); #1;
        chk("abort_no_done", 64'(dones[0] - dn0), 64'd0);
        run_frame(0, "after_abort", rand_vec());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
